// File: rtl/i2c_cmd_scheduler.sv
`default_nettype none
// i2c_cmd_scheduler: round-robin sharing of one 24-bit I2C write engine, with completion watchdog and idle gap.
// Optional macro I2C_SCHED_RETRY_EN: a timed-out frame is reissued up to two more times before being dropped.
module i2c_cmd_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 65535,
    parameter int GAP_CYC     = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [24*NUM_REQ-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_send_start,
    output logic [23:0]            o_send_data,
    input  logic                   i_send_finished,
    output logic                   o_busy,
    output logic                   o_cmd_done,
    output logic [1:0]             o_cmd_id,
    output logic                   o_timeout,
    output logic                   o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    // A zero-length gap skips the GAP state entirely.
    localparam state_t           AFTER_WAIT   = (GAP_CYC > 0) ? GAP : IDLE;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         rr_ptr;
    logic               grant_found;
    logic [1:0]         grant_idx;
    logic [1:0]         next_ptr;
    logic [23:0]        grant_data;
    logic [2:0]         arb_sum;
    logic [1:0]         arb_idx;
`ifdef I2C_SCHED_RETRY_EN
    logic [1:0]         retry_cnt;
`endif

    // rr_ptr holds the index with highest priority; search wraps from there.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        arb_sum     = 3'd0;
        arb_idx     = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_sum = {1'b0, rr_ptr} + 3'(i);
            arb_idx = (arb_sum >= 3'(NUM_REQ)) ? 2'(arb_sum - 3'(NUM_REQ)) : arb_sum[1:0];
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_found && arb_idx == 2'(k) && i_req_valid[k]) begin
                    grant_found = 1'b1;
                    grant_idx   = 2'(k);
                end
            end
        end
    end

    always_comb begin
        grant_data = 24'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == 2'(k)) begin
                grant_data = i_req_data[24*k +: 24];
            end
        end
    end

    assign next_ptr = (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;

    // Gated by i_rst so ready drops immediately while reset is held.
    always_comb begin
        o_req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_req_ready[k] = i_rst && (state == IDLE) && grant_found && (grant_idx == 2'(k));
        end
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rr_ptr       <= 2'd0;
            o_send_start <= 1'b0;
            o_send_data  <= 24'd0;
            o_cmd_done   <= 1'b0;
            o_cmd_id     <= 2'd0;
            o_timeout    <= 1'b0;
            o_err        <= 1'b0;
`ifdef I2C_SCHED_RETRY_EN
            retry_cnt    <= 2'd0;
`endif
        end else begin
            o_send_start <= 1'b0;
            o_cmd_done   <= 1'b0;
            o_timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        o_send_data  <= grant_data;
                        o_cmd_id     <= grant_idx;
                        rr_ptr       <= next_ptr;
                        o_send_start <= 1'b1;
                        state        <= ISSUE;
`ifdef I2C_SCHED_RETRY_EN
                        retry_cnt    <= 2'd0;
`endif
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Completion takes precedence over a simultaneous watchdog expiry.
                    if (i_send_finished) begin
                        o_cmd_done <= 1'b1;
                        cnt        <= '0;
                        state      <= AFTER_WAIT;
                    end else if (cnt == TIMEOUT_LAST) begin
                        o_timeout <= 1'b1;
                        cnt       <= '0;
`ifdef I2C_SCHED_RETRY_EN
                        if (retry_cnt != 2'd2) begin
                            retry_cnt    <= retry_cnt + 2'd1;
                            o_send_start <= 1'b1;
                            state        <= ISSUE;
                        end else begin
                            o_err <= 1'b1;
                            state <= AFTER_WAIT;
                        end
`else
                        o_err <= 1'b1;
                        state <= AFTER_WAIT;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_scheduler.sv
`default_nettype none
// tb_i2c_cmd_scheduler: directed checks of arbitration, watchdog, gap, reset and optional retry.
module tb_i2c_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  valid = 2'b00;
    logic [23:0] d0 = 24'd0;
    logic [23:0] d1 = 24'd0;
    logic [47:0] req_data;
    logic [1:0]  ready;
    logic        send_start;
    logic [23:0] send_data;
    logic        finished = 1'b0;
    logic        busy;
    logic        cmd_done;
    logic [1:0]  cmd_id;
    logic        timeout;
    logic        err;

    int total = 0;
    int bad   = 0;

`ifdef I2C_SCHED_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    assign req_data = {d1, d0};

    always #5 clk = ~clk;

    i2c_cmd_scheduler #(
        .NUM_REQ(2),
        .TIMEOUT_CYC(100),
        .GAP_CYC(16),
        .CNT_W(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_req_valid(valid),
        .i_req_data(req_data),
        .o_req_ready(ready),
        .o_send_start(send_start),
        .o_send_data(send_data),
        .i_send_finished(finished),
        .o_busy(busy),
        .o_cmd_done(cmd_done),
        .o_cmd_id(cmd_id),
        .o_timeout(timeout),
        .o_err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        valid    = 2'b00;
        finished = 1'b0;
        rst      = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready == 2'b00 && n < 60) begin
            step();
            n++;
        end
        check(tag, 32'(ready != 2'b00), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            step();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt0;
        int cnt1;
        int exp_k;
        logic [23:0] exp_frame;

        // Reset state
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(send_start), 32'd0);
        check("rst_data", 32'(send_data), 32'd0);
        check("rst_done", 32'(cmd_done), 32'd0);
        check("rst_id", 32'(cmd_id), 32'd0);
        check("rst_to", 32'(timeout), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        step();

        // Single command, engine finishes 50 cycles after start
        d0 = 24'h340097;
        valid = 2'b01;
        #1 check("single_ready", 32'(ready), 32'h1);
        step();
        valid = 2'b00;
        check("single_start", 32'(send_start), 32'd1);
        check("single_data", 32'(send_data), 32'h340097);
        check("single_noready", 32'(ready), 32'd0);
        step();
        check("single_start_pulse", 32'(send_start), 32'd0);
        repeat (48) step();
        finished = 1'b1;
        step();
        finished = 1'b0;
        check("single_done", 32'(cmd_done), 32'd1);
        check("single_id", 32'(cmd_id), 32'd0);
        check("single_noto", 32'(timeout), 32'd0);
        step();
        check("single_done_pulse", 32'(cmd_done), 32'd0);
        repeat (14) step();
        check("single_gap_busy", 32'(busy), 32'd1);
        step();
        check("single_gap_end", 32'(busy), 32'd0);

        // Contention: both requesters hold three commands each
        do_reset();
        cnt0 = 0;
        cnt1 = 0;
        d0 = 24'hA00000;
        d1 = 24'hA01000;
        valid = 2'b11;
        for (int g = 0; g < 6; g++) begin
            exp_k = g % 2;
            #1 wait_ready("cont_wait");
            check("cont_onehot", 32'(ready), 32'(1 << exp_k));
            exp_frame = (exp_k == 0) ? d0 : d1;
            step();
            check("cont_data", 32'(send_data), 32'(exp_frame));
            if (exp_k == 0) begin
                cnt0++;
                d0 = 24'hA00000 | 24'(cnt0);
                if (cnt0 == 3) valid[0] = 1'b0;
            end else begin
                cnt1++;
                d1 = 24'hA01000 | 24'(cnt1);
                if (cnt1 == 3) valid[1] = 1'b0;
            end
            step();
            finished = 1'b1;
            step();
            finished = 1'b0;
            check("cont_done_id", 32'({cmd_done, cmd_id}), 32'({1'b1, 2'(exp_k)}));
        end
        wait_idle("cont_idle");

        // Watchdog: engine never answers; req1 queued behind req0
        d0 = 24'h4C1234;
        d1 = 24'h4E5678;
        valid = 2'b11;
        #1 check("to_ready0", 32'(ready), 32'h1);
        step();
        valid = 2'b10;
        for (int a = 0; a < ATTEMPTS; a++) begin
            check("to_start", 32'(send_start), 32'd1);
            check("to_data", 32'(send_data), 32'h4C1234);
            // WAIT holds cnt 0..99 during the 100 cycles after start; the pulse is registered one cycle later.
            repeat (100) step();
            check("to_early", 32'(timeout), 32'd0);
            step();
            check("to_pulse", 32'(timeout), 32'd1);
            check("to_err", 32'(err), 32'(a == ATTEMPTS - 1));
        end
        step();
        check("to_pulse_end", 32'(timeout), 32'd0);
        wait_ready("to_next_wait");
        check("to_next_ready", 32'(ready), 32'h2);
        step();
        valid = 2'b00;
        check("to_next_data", 32'(send_data), 32'h4E5678);
        step();
        finished = 1'b1;
        step();
        finished = 1'b0;
        check("to_next_done", 32'(cmd_done), 32'd1);
        check("to_err_sticky", 32'(err), 32'd1);

        // Race: finish in the same cycle the counter hits TIMEOUT_CYC-1
        do_reset();
        d0 = 24'h341122;
        valid = 2'b01;
        #1 check("race_ready", 32'(ready), 32'h1);
        step();
        valid = 2'b00;
        repeat (100) step();
        finished = 1'b1;
        step();
        finished = 1'b0;
        check("race_done", 32'(cmd_done), 32'd1);
        check("race_noto", 32'(timeout), 32'd0);
        check("race_err", 32'(err), 32'd0);
        wait_idle("race_idle");

        // Asynchronous reset in the middle of WAIT
        d0 = 24'h123456;
        valid = 2'b01;
        step();
        check("mid_start", 32'(send_start), 32'd1);
        repeat (5) step();
        d1 = 24'h6789AB;
        valid = 2'b10;
        rst = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ready", 32'(ready), 32'd0);
        check("mid_data", 32'(send_data), 32'd0);
        check("mid_id", 32'(cmd_id), 32'd0);
        check("mid_flags", 32'({send_start, cmd_done, timeout, err}), 32'd0);
        step();
        rst = 1'b1;
        #1 check("mid_req1_ready", 32'(ready), 32'h2);
        step();
        valid = 2'b00;
        check("mid_req1_data", 32'(send_data), 32'h6789AB);
        check("mid_req1_id", 32'(cmd_id), 32'd1);

`ifdef I2C_SCHED_RETRY_EN
        // Retry succeeds on the third attempt
        do_reset();
        d0 = 24'h34ABCD;
        valid = 2'b01;
        step();
        valid = 2'b00;
        check("rty_start1", 32'({send_start, send_data}), 32'({1'b1, 24'h34ABCD}));
        repeat (101) step();
        check("rty_start2", 32'({timeout, send_start, send_data}), 32'({2'b11, 24'h34ABCD}));
        repeat (101) step();
        check("rty_start3", 32'({timeout, send_start, send_data}), 32'({2'b11, 24'h34ABCD}));
        repeat (5) step();
        finished = 1'b1;
        step();
        finished = 1'b0;
        check("rty_done", 32'({cmd_done, timeout, err}), 32'b100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
